// File: rtl/instr_prefetch_buffer_if.sv
// Bus bundle tying the prefetch buffer to instruction memory, the branch unit and the fetch consumer.
// Defining MISALIGN_CHECK_EN adds the sticky misaligned flag to the bundle.
interface instr_prefetch_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [31:0]       redirect_addr;
  logic              instr_ready;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic [31:0]       pc_plus4;
  logic [CNT_W-1:0]  count;

`ifdef MISALIGN_CHECK_EN
  logic              misaligned;

  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_addr,
    input  instr_ready,
    output instr_valid,
    output instr,
    output instr_pc,
    output pc_plus4,
    output count,
    output misaligned
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_addr,
    output instr_ready,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  pc_plus4,
    input  count,
    input  misaligned
  );
`else
  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_addr,
    input  instr_ready,
    output instr_valid,
    output instr,
    output instr_pc,
    output pc_plus4,
    output count
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_addr,
    output instr_ready,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    input  pc_plus4,
    input  count
  );
`endif
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Byte-serial instruction prefetcher: assembles big-endian 32-bit words and queues them with their PC.
// Optional MISALIGN_CHECK_EN flags redirect targets whose low two bits are non-zero.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_buffer_if.master bus
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [31:0]      START_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [1:0]       b_q, b_d;
  logic [31:0]      word_q, word_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      fifo_instr_q [DEPTH];
  logic [31:0]      fifo_pc_q    [DEPTH];

  logic             valid;
  logic             pop;
  logic             space;
  logic             push;

  assign valid = (count_q != '0);
  // A redirect flushes the queue, so a pop in that cycle must not move the read pointer.
  assign pop   = valid & bus.instr_ready & ~bus.redirect;
  assign space = (count_q < DEPTH_C) | pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    b_d        = b_q;
    word_d     = word_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;

    if (bus.redirect) begin
      state_d    = S_FETCH;
      b_d        = 2'd0;
      fetch_pc_d = {bus.redirect_addr[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          // Lane index 3-b puts byte 0 in bits [31:24] (big-endian).
          word_d[{~b_q, 3'b000} +: 8] = bus.mem_data;
          if (b_q != 2'd3) begin
            b_d = b_q + 2'd1;
          end else if (space) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            b_d        = 2'd0;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (space) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            b_d        = 2'd0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= START_PC;
      b_q        <= 2'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      b_q        <= b_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Datapath storage carries no reset; slots are only observed while count covers them.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= word_d;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // While holding, memory is already pointed at byte 0 of the following word.
  assign bus.mem_addr = fetch_pc_q[ADDR_W-1:0] +
                        ((state_q == S_HOLD) ? ADDR_W'(4) : ADDR_W'(b_q));

  assign bus.instr_valid = valid;
  assign bus.count       = count_q;
  assign bus.instr       = valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
  assign bus.instr_pc    = valid ? fifo_pc_q[rd_ptr_q] : 32'd0;
  assign bus.pc_plus4    = valid ? (fifo_pc_q[rd_ptr_q] + 32'd4) : 32'd0;

`ifdef MISALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (bus.redirect && (bus.redirect_addr[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign bus.misaligned = misaligned_q;
`else
  logic unused_align_bits;
  assign unused_align_bits = ^bus.redirect_addr[1:0];
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: one DUT at RESET_PC=0, one at RESET_PC=0xFC sharing a ROM.
module tb_instr_prefetch_buffer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  instr_prefetch_buffer_if #(.DEPTH(4), .ADDR_W(8)) bus_a ();
  instr_prefetch_buffer_if #(.DEPTH(4), .ADDR_W(8)) bus_b ();

  assign bus_a.mem_data = mem[bus_a.mem_addr];
  assign bus_b.mem_data = mem[bus_b.mem_addr];

  instr_prefetch_buffer #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  instr_prefetch_buffer #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'hFC)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic ready);
    reset               = 1'b1;
    bus_a.redirect      = 1'b0;
    bus_a.redirect_addr = 32'h0;
    bus_a.instr_ready   = ready;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b_addr;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h04;
    bus_b.redirect      = 1'b0;
    bus_b.redirect_addr = 32'h0;
    bus_b.instr_ready   = 1'b1;

    // Test 1 (DUT A) and test 5 (DUT B) run side by side from the same reset.
    do_reset(1'b1);
    chk("rst_count",  32'(bus_a.count), 32'd0);
    chk("rst_valid",  32'(bus_a.instr_valid), 32'd0);
    chk("rst_instr",  bus_a.instr, 32'd0);
    chk("rst_pc",     bus_a.instr_pc, 32'd0);
    chk("rst_pc4",    bus_a.pc_plus4, 32'd0);
    chk("rst_addr",   32'(bus_a.mem_addr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp_b_addr = 8'(8'hFC + i);
      chk("b_addr", 32'(bus_b.mem_addr), 32'(exp_b_addr));
      tick();
      if (i == 2) chk("t1_valid_e3", 32'(bus_a.instr_valid), 32'd0);
      if (i == 3) begin
        chk("t1_valid_e4", 32'(bus_a.instr_valid), 32'd1);
        chk("t1_instr0",   bus_a.instr, 32'h20080005);
        chk("t1_pc0",      bus_a.instr_pc, 32'h0);
        chk("t1_pc4_0",    bus_a.pc_plus4, 32'h4);
        chk("t5_instr0",   bus_b.instr, 32'hFCFDFEFF);
        chk("t5_pc0",      bus_b.instr_pc, 32'hFC);
      end
    end
    chk("t1_instr1", bus_a.instr, 32'h8C090004);
    chk("t1_pc1",    bus_a.instr_pc, 32'h4);
    chk("t5_instr1", bus_b.instr, 32'h20080005);
    chk("t5_pc1",    bus_b.instr_pc, 32'h100);
    chk("t5_pc4_1",  bus_b.pc_plus4, 32'h104);

    // Test 2: fill, enter hold, single pop lets the held word in.
    do_reset(1'b0);
    ticks(16);
    chk("t2_full", 32'(bus_a.count), 32'd4);
    ticks(3);
    chk("t2_addr_e19", 32'(bus_a.mem_addr), 32'h13);
    tick();
    chk("t2_hold_addr", 32'(bus_a.mem_addr), 32'h14);
    chk("t2_hold_cnt",  32'(bus_a.count), 32'd4);
    chk("t2_hold_pc",   bus_a.instr_pc, 32'h0);
    bus_a.instr_ready = 1'b1;
    tick();
    chk("t2_pop_cnt",   32'(bus_a.count), 32'd4);
    chk("t2_pop_pc",    bus_a.instr_pc, 32'h4);
    chk("t2_pop_instr", bus_a.instr, 32'h8C090004);
    ticks(3);
    chk("t2_held_instr", bus_a.instr, 32'h10111213);
    chk("t2_held_pc",    bus_a.instr_pc, 32'h10);
    chk("t2_held_cnt",   32'(bus_a.count), 32'd1);

    // Test 3: redirect mid-word while the queue holds two words.
    do_reset(1'b0);
    ticks(10);
    chk("t3_pre_cnt", 32'(bus_a.count), 32'd2);
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h40;
    tick();
    bus_a.redirect = 1'b0;
    chk("t3_cnt",   32'(bus_a.count), 32'd0);
    chk("t3_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("t3_addr",  32'(bus_a.mem_addr), 32'h40);
    ticks(3);
    chk("t3_valid_e3", 32'(bus_a.instr_valid), 32'd0);
    tick();
    chk("t3_valid_e4", 32'(bus_a.instr_valid), 32'd1);
    chk("t3_pc",       bus_a.instr_pc, 32'h40);
    chk("t3_instr",    bus_a.instr, 32'h40414243);

    // Test 4: redirect and ready together on a full queue; pops while empty ignored.
    do_reset(1'b0);
    ticks(16);
    chk("t4_full", 32'(bus_a.count), 32'd4);
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h80;
    bus_a.instr_ready   = 1'b1;
    tick();
    bus_a.redirect = 1'b0;
    chk("t4_cnt",   32'(bus_a.count), 32'd0);
    chk("t4_instr", bus_a.instr, 32'd0);
    chk("t4_addr",  32'(bus_a.mem_addr), 32'h80);
    ticks(4);
    chk("t4_new_cnt",   32'(bus_a.count), 32'd1);
    chk("t4_new_pc",    bus_a.instr_pc, 32'h80);
    chk("t4_new_instr", bus_a.instr, 32'h80818283);

    // Test 6: reset from hold, then a misaligned redirect.
    do_reset(1'b0);
    ticks(20);
    chk("t6_hold_cnt", 32'(bus_a.count), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cnt",   32'(bus_a.count), 32'd0);
    chk("t6_valid", 32'(bus_a.instr_valid), 32'd0);
    chk("t6_addr",  32'(bus_a.mem_addr), 32'h0);
    chk("t6_pc4",   bus_a.pc_plus4, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("t6_mis_clr", 32'(bus_a.misaligned), 32'd0);
`endif
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h42;
    tick();
    bus_a.redirect = 1'b0;
    chk("t6_mis_addr", 32'(bus_a.mem_addr), 32'h40);
`ifdef MISALIGN_CHECK_EN
    chk("t6_mis_set", 32'(bus_a.misaligned), 32'd1);
`endif
    ticks(4);
    chk("t6_mis_pc",    bus_a.instr_pc, 32'h40);
    chk("t6_mis_instr", bus_a.instr, 32'h40414243);
`ifdef MISALIGN_CHECK_EN
    bus_a.redirect      = 1'b1;
    bus_a.redirect_addr = 32'h0;
    tick();
    bus_a.redirect = 1'b0;
    chk("t6_mis_sticky", 32'(bus_a.misaligned), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
